// File: rtl/fir_out_buffer.sv
// Output stage behind the FIR accumulator: rounds, shifts and saturates each result,
// then queues it in a small FIFO drained over a valid/ready handshake.
module fir_out_buffer #(
    parameter int unsigned ACC_W = 40,
    parameter int unsigned OUT_W = 16,
    parameter int unsigned SHIFT = 15,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         fir_valid,
    input  logic signed [ACC_W-1:0]      fir_data,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic signed [OUT_W-1:0]      m_data,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         full,
    output logic                         overflow,
    input  logic                         clr_ovf
);

    localparam int unsigned PtrW  = $clog2(DEPTH);
    localparam int unsigned LvlW  = $clog2(DEPTH + 1);
    localparam int unsigned RndSh = (SHIFT == 0) ? 0 : SHIFT - 1;

    localparam logic signed [ACC_W:0] One    = {{ACC_W{1'b0}}, 1'b1};
    localparam logic signed [ACC_W:0] RoundC = (SHIFT == 0) ? '0 : (One << RndSh);
    localparam logic signed [ACC_W:0] SatMax = {{(ACC_W + 2 - OUT_W){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [ACC_W:0] SatMin = {{(ACC_W + 2 - OUT_W){1'b1}}, {(OUT_W - 1){1'b0}}};

    logic signed [ACC_W:0]   sum;
    logic signed [ACC_W:0]   shifted;
    logic signed [OUT_W-1:0] sat_val;

    logic                    s_v_q;
    logic signed [OUT_W-1:0] s_r_q;
    logic [OUT_W-1:0]        mem_q [DEPTH];
    logic [PtrW-1:0]         wr_ptr_q;
    logic [PtrW-1:0]         rd_ptr_q;
    logic [LvlW-1:0]         level_q;
    logic [LvlW-1:0]         level_d;
    logic                    ovf_q;
    logic                    ovf_d;

    logic pop;
    logic push;
    logic drop;

    // One extra bit of headroom keeps the rounding add from wrapping.
    always_comb begin
        sum     = $signed({fir_data[ACC_W-1], fir_data}) + RoundC;
        shifted = sum >>> SHIFT;
        if (shifted > SatMax) begin
            sat_val = SatMax[OUT_W-1:0];
        end else if (shifted < SatMin) begin
            sat_val = SatMin[OUT_W-1:0];
        end else begin
            sat_val = shifted[OUT_W-1:0];
        end
    end

    // A pop in the same cycle frees the slot, so a push at full is still accepted.
    assign pop  = (level_q != '0) & m_ready;
    assign push = s_v_q & ((level_q < LvlW'(DEPTH)) | pop);
    assign drop = s_v_q & ~push;

    always_comb begin
        level_d = level_q;
        if (push & ~pop) begin
            level_d = level_q + LvlW'(1);
        end else if (pop & ~push) begin
            level_d = level_q - LvlW'(1);
        end
        ovf_d = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_v_q    <= 1'b0;
            s_r_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            s_v_q <= fir_valid;
            if (fir_valid) begin
                s_r_q <= sat_val;
            end
            if (push) begin
                mem_q[wr_ptr_q] <= s_r_q;
                wr_ptr_q        <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            level_q <= level_d;
            ovf_q   <= ovf_d;
        end
    end

    assign m_valid  = (level_q != '0);
    assign m_data   = m_valid ? mem_q[rd_ptr_q] : '0;
    assign level    = level_q;
    assign full     = (level_q == LvlW'(DEPTH));
    assign overflow = ovf_q;

endmodule

// File: tb/tb_fir_out_buffer.sv
// Randomised and directed bench for fir_out_buffer: a queue-based reference model
// predicts every delivered sample, occupancy and the sticky overflow flag.
module tb_fir_out_buffer;

    localparam int ACC_W = 40;
    localparam int OUT_W = 16;
    localparam int SHIFT = 15;
    localparam int DEPTH = 4;
    localparam int LvlW  = $clog2(DEPTH + 1);

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    fir_valid;
    logic signed [ACC_W-1:0] fir_data;
    logic                    m_valid;
    logic                    m_ready;
    logic signed [OUT_W-1:0] m_data;
    logic [LvlW-1:0]         level;
    logic                    full;
    logic                    overflow;
    logic                    clr_ovf;

    int     total = 0;
    int     bad   = 0;
    longint issued[$];
    longint mq[$];
    bit     stage_v = 1'b0;
    longint stage_val = 0;
    bit     movf = 1'b0;

    fir_out_buffer #(
        .ACC_W(ACC_W),
        .OUT_W(OUT_W),
        .SHIFT(SHIFT),
        .DEPTH(DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .fir_valid(fir_valid),
        .fir_data (fir_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .level    (level),
        .full     (full),
        .overflow (overflow),
        .clr_ovf  (clr_ovf)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, longint act, longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Round half up, floor shift, clamp to the signed output range.
    function automatic longint ref_out(logic signed [ACC_W-1:0] d);
        longint v;
        longint hi;
        longint lo;
        v  = longint'(d);
        hi = (longint'(1) <<< (OUT_W - 1)) - 1;
        lo = -(longint'(1) <<< (OUT_W - 1));
        if (SHIFT > 0) v = v + (longint'(1) <<< (SHIFT - 1));
        v = v >>> SHIFT;
        if (v > hi) v = hi;
        if (v < lo) v = lo;
        return v;
    endfunction

    // Reference model and monitor: checks what the DUT shows now, then advances the
    // model to the state expected after the coming rising edge.
    always @(negedge clk) begin
        bit pop;
        bit drop;
        if (!rst_n) begin
            mq.delete();
            issued.delete();
            stage_v = 1'b0;
            movf    = 1'b0;
            chk("rst_m_valid", longint'(m_valid), 0);
            chk("rst_m_data", longint'(m_data), 0);
            chk("rst_level", longint'(level), 0);
            chk("rst_overflow", longint'(overflow), 0);
        end else begin
            chk("m_valid", longint'(m_valid), longint'(mq.size() != 0));
            chk("level", longint'(level), longint'(mq.size()));
            chk("full", longint'(full), longint'(mq.size() == DEPTH));
            chk("overflow", longint'(overflow), longint'(movf));
            if (m_valid && mq.size() != 0) begin
                chk("m_data", longint'(m_data), mq[0]);
            end
            pop  = (mq.size() != 0) && m_ready;
            drop = 1'b0;
            if (stage_v) begin
                if (mq.size() < DEPTH || pop) mq.push_back(stage_val);
                else drop = 1'b1;
            end
            if (pop) void'(mq.pop_front());
            if (drop) movf = 1'b1;
            else if (clr_ovf) movf = 1'b0;
            stage_v = fir_valid;
            if (fir_valid) stage_val = (issued.size() != 0) ? issued.pop_front() : 0;
        end
    end

    task automatic drive(input bit v, input longint d, input bit rdy, input bit clr);
        fir_valid = v;
        fir_data  = d[ACC_W-1:0];
        m_ready   = rdy;
        clr_ovf   = clr;
        if (v) issued.push_back(ref_out(fir_data));
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_check(input string name, input longint d, input longint exp);
        drive(1'b1, d, 1'b1, 1'b0);
        chk({name, "_lat_n1"}, longint'(m_valid), 0);
        drive(1'b0, 0, 1'b1, 1'b0);
        chk({name, "_lat_n2"}, longint'(m_valid), 1);
        chk(name, longint'(m_data), exp);
    endtask

    initial begin
        longint r;
        rst_n     = 1'b1;
        fir_valid = 1'b0;
        fir_data  = '0;
        m_ready   = 1'b0;
        clr_ovf   = 1'b0;
        #3 rst_n  = 1'b0;
        #1;
        chk("init_m_valid", longint'(m_valid), 0);
        chk("init_level", longint'(level), 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        drive(1'b0, 0, 1'b1, 1'b0);

        // Rounding and saturation corners, plus two-cycle latency.
        pulse_check("round_up", 16384, 1);
        pulse_check("round_dn", 16383, 0);
        pulse_check("sat_pos", longint'(1) <<< 31, 32767);
        pulse_check("sat_neg", -(longint'(1) <<< 31), -32768);
        pulse_check("neg_half", -16385, -1);
        drive(1'b0, 0, 1'b1, 1'b0);

        // Stalled consumer overflows on the fifth result, then drains in order.
        for (int i = 1; i <= 5; i++) drive(1'b1, longint'(i) <<< 15, 1'b0, 1'b0);
        drive(1'b0, 0, 1'b0, 1'b0);
        chk("ovf_level", longint'(level), 4);
        chk("ovf_full", longint'(full), 1);
        chk("ovf_flag", longint'(overflow), 1);
        for (int k = 1; k <= 4; k++) begin
            chk("drain_data", longint'(m_data), longint'(k));
            drive(1'b0, 0, 1'b1, 1'b0);
        end
        chk("drain_level", longint'(level), 0);
        chk("drain_valid", longint'(m_valid), 0);

        // Push coincident with pop at full, streamed across pointer wrap.
        drive(1'b0, 0, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) drive(1'b1, longint'(100 + i) <<< 15, 1'b0, 1'b0);
        for (int i = 5; i < 15; i++) begin
            drive(1'b1, longint'(100 + i) <<< 15, 1'b1, 1'b0);
            chk("stream_level", longint'(level), 4);
            chk("stream_ovf", longint'(overflow), 0);
        end
        repeat (8) drive(1'b0, 0, 1'b1, 1'b0);

        // Asynchronous reset with three queued results and one in the capture stage.
        for (int i = 1; i <= 4; i++) drive(1'b1, longint'(40 + i) <<< 15, 1'b0, 1'b0);
        chk("pre_rst_level", longint'(level), 3);
        fir_valid = 1'b0;
        rst_n     = 1'b0;
        #1;
        chk("arst_m_valid", longint'(m_valid), 0);
        chk("arst_m_data", longint'(m_data), 0);
        chk("arst_level", longint'(level), 0);
        chk("arst_full", longint'(full), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) drive(1'b0, 0, 1'b1, 1'b0);
        chk("post_rst_valid", longint'(m_valid), 0);

        // Overflow clear, and a drop coinciding with the clear keeps the flag set.
        for (int i = 1; i <= 5; i++) drive(1'b1, longint'(i) <<< 15, 1'b0, 1'b0);
        drive(1'b0, 0, 1'b0, 1'b0);
        chk("ovf_set", longint'(overflow), 1);
        drive(1'b0, 0, 1'b0, 1'b1);
        chk("ovf_cleared", longint'(overflow), 0);
        drive(1'b1, longint'(7) <<< 15, 1'b0, 1'b0);
        drive(1'b0, 0, 1'b0, 1'b1);
        chk("ovf_set_wins", longint'(overflow), 1);
        repeat (6) drive(1'b0, 0, 1'b1, 1'b1);

        // Random traffic: mixed magnitudes, bursty consumer, occasional clears.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 1) == 0) r = longint'($urandom_range(0, 2097152)) - 1048576;
            else r = {$urandom, $urandom};
            drive($urandom_range(0, 9) < 7, r,
                  ((c / 64) % 3 == 2) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0),
                  $urandom_range(0, 31) == 0);
        end
        repeat (8) drive(1'b0, 0, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
